// File: rtl/rfile_mp.sv
// Multi-read, dual-write register file with bulk-clear sequencer, optional zero register and write-collision flag.
// Build option: define RFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.

module rfile_mp_rd #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] mem,
  input  logic [ADDR_W-1:0]                  addr,
  input  logic                               blank,
`ifdef RFILE_BYPASS_EN
  input  logic                               wen_a,
  input  logic [ADDR_W-1:0]                  waddr_a,
  input  logic [DATA_W-1:0]                  wdata_a,
  input  logic                               wen_b,
  input  logic [ADDR_W-1:0]                  waddr_b,
  input  logic [DATA_W-1:0]                  wdata_b,
`endif
  output logic [DATA_W-1:0]                  data
);
  always_comb begin
    data = mem[addr];
`ifdef RFILE_BYPASS_EN
    // B is listed first so it wins when both ports hit this address
    if (wen_b && waddr_b == addr)      data = wdata_b;
    else if (wen_a && waddr_a == addr) data = wdata_a;
`endif
    if (blank || (ZERO_REG != 0 && addr == '0)) data = '0;
  end
endmodule

module rfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en_a,
  input  logic [ADDR_W-1:0]        wr_addr_a,
  input  logic [DATA_W-1:0]        wr_data_a,
  input  logic                     wr_en_b,
  input  logic [ADDR_W-1:0]        wr_addr_b,
  input  logic [DATA_W-1:0]        wr_data_b,
  output logic                     wr_conflict
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                         state;
  logic [ADDR_W-1:0]              clr_ptr;
  logic [DEPTH-1:0][DATA_W-1:0]   mem;
  logic                           open;
  logic                           we_a, we_b;

  assign busy = rst || (state == CLEAR);
  assign open = !rst && (state == IDLE);
  assign we_a = open && wr_en_a && !(ZERO_REG != 0 && wr_addr_a == '0);
  assign we_b = open && wr_en_b && !(ZERO_REG != 0 && wr_addr_b == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clr_ptr     <= '0;
      wr_conflict <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wr_conflict <= wr_en_a && wr_en_b && (wr_addr_a == wr_addr_b);
          if (clr_req) begin
            state   <= CLEAR;
            clr_ptr <= '0;
          end
        end
        CLEAR: begin
          wr_conflict <= 1'b0;
          clr_ptr     <= clr_ptr + 1'b1;
          if (clr_ptr == LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage has no reset; the clear sequencer zeroes it after rst drops.
  // On a same-address A/B write the later B assignment takes effect.
  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else begin
      if (we_a) mem[wr_addr_a] <= wr_data_a;
      if (we_b) mem[wr_addr_b] <= wr_data_b;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    rfile_mp_rd #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .mem     (mem),
      .addr    (rd_addr[i*ADDR_W +: ADDR_W]),
      .blank   (busy),
`ifdef RFILE_BYPASS_EN
      .wen_a   (wr_en_a),
      .waddr_a (wr_addr_a),
      .wdata_a (wr_data_a),
      .wen_b   (wr_en_b),
      .waddr_b (wr_addr_b),
      .wdata_b (wr_data_b),
`endif
      .data    (rd_data[i*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_rfile_mp.sv
// Bench for rfile_mp: directed scenarios plus randomized traffic checked every cycle against a behavioural model.
module tb_rfile_mp;
  localparam int DW = 32, AW = 5, NR = 2, ZR = 1, DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst, clr_req, busy, wr_conflict;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic              wr_en_a, wr_en_b;
  logic [AW-1:0]     wr_addr_a, wr_addr_b;
  logic [DW-1:0]     wr_data_a, wr_data_b;

  int n_vec = 0, n_err = 0;
  bit chk_en = 0;

  rfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(ZR)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  // Behavioural model: register array plus count of clear cycles still owed.
  logic [DW-1:0] m_mem [DEPTH];
  int  clr_left = 0;
  bit  m_conf = 0;

  always @(posedge clk) begin
    if (rst) begin
      clr_left = DEPTH;
      m_conf   = 0;
    end else if (clr_left > 0) begin
      m_mem[DEPTH - clr_left] = '0;
      clr_left = clr_left - 1;
      m_conf   = 0;
    end else begin
      m_conf = wr_en_a && wr_en_b && (wr_addr_a == wr_addr_b);
      if (wr_en_a && !(ZR != 0 && wr_addr_a == 0)) m_mem[wr_addr_a] = wr_data_a;
      if (wr_en_b && !(ZR != 0 && wr_addr_b == 0)) m_mem[wr_addr_b] = wr_data_b;
      if (clr_req) clr_left = DEPTH;
    end
  end

  function automatic bit exp_busy();
    return rst || (clr_left > 0);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (exp_busy()) return '0;
    if (ZR != 0 && a == 0) return '0;
`ifdef RFILE_BYPASS_EN
    if (wr_en_b && wr_addr_b == a) return wr_data_b;
    if (wr_en_a && wr_addr_a == a) return wr_data_a;
`endif
    return m_mem[a];
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  // Single compare process, 2 time units after the falling edge.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      check("busy", DW'(busy), DW'(exp_busy()));
      check("wr_conflict", DW'(wr_conflict), DW'(m_conf));
      for (int i = 0; i < NR; i++)
        check($sformatf("rd_data[%0d]", i), rd_data[i*DW +: DW], exp_rd(rd_addr[i*AW +: AW]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_rd(input int p0, input int p1);
    rd_addr = {AW'(p1), AW'(p0)};
  endtask

  task automatic wr_off();
    wr_en_a = 0; wr_en_b = 0;
  endtask

  // Counts consecutive busy samples starting at the current negedge.
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      #3;
      if (!busy) return;
      n++;
      tick();
    end
    n_err++;
    $display("FAIL busy_timeout: busy still high after %0d cycles, expected drop", n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1; clr_req = 0; rd_addr = '0;
    wr_en_a = 0; wr_addr_a = '0; wr_data_a = '0;
    wr_en_b = 0; wr_addr_b = '0; wr_data_b = '0;

    // 1: reset for 4 edges, then a full clear of DEPTH cycles
    @(posedge clk);
    chk_en = 1;
    repeat (3) @(posedge clk);
    tick(); rst = 0;
    count_busy(n);
    check("busy_after_rst", DW'(n), 32);
    for (int r = 0; r < DEPTH; r += 2) begin
      tick(); set_rd(r, r + 1); #3;
      check("cleared_p0", rd_data[0 +: DW], 32'h0);
      check("cleared_p1", rd_data[DW +: DW], 32'h0);
    end

    // 2: distinct-address dual write
    tick(); set_rd(1, 2);
    wr_en_a = 1; wr_addr_a = 1; wr_data_a = 32'h55;
    wr_en_b = 1; wr_addr_b = 2; wr_data_b = 32'hD5;
    tick(); wr_off(); #3;
    check("r1", rd_data[0 +: DW], 32'h0000_0055);
    check("r2", rd_data[DW +: DW], 32'h0000_00D5);
    check("no_conflict", DW'(wr_conflict), 0);

    // 3: zero register
    tick(); set_rd(0, 0);
    wr_en_a = 1; wr_addr_a = 0; wr_data_a = 32'hFFFF_FFFF; #3;
    check("r0_same_cycle", rd_data[0 +: DW], 32'h0);
    tick(); wr_off(); #3;
    check("r0_after", rd_data[0 +: DW], 32'h0);

    // 4: same-address collision, B wins, one-cycle flag
    tick();
    wr_en_a = 1; wr_addr_a = 3; wr_data_a = 32'h11;
    wr_en_b = 1; wr_addr_b = 3; wr_data_b = 32'h22;
    tick(); wr_off(); set_rd(3, 3); #3;
    check("r3_b_wins", rd_data[0 +: DW], 32'h22);
    check("conflict_hi", DW'(wr_conflict), 1);
    tick(); #3;
    check("conflict_lo", DW'(wr_conflict), 0);

    // 5: read-during-write of r5
    tick(); set_rd(5, 4);
    wr_en_a = 1; wr_addr_a = 5; wr_data_a = 32'h75; #3;
`ifdef RFILE_BYPASS_EN
    check("r5_same_cycle", rd_data[0 +: DW], 32'h75);
`else
    check("r5_same_cycle", rd_data[0 +: DW], 32'h0);
`endif
    tick(); wr_off(); #3;
    check("r5_next", rd_data[0 +: DW], 32'h75);

    // 6: bulk clear on request, writes during clear dropped
    tick(); wr_en_a = 1; wr_addr_a = 1; wr_data_a = 32'h101;
            wr_en_b = 1; wr_addr_b = 2; wr_data_b = 32'h202;
    tick(); wr_en_b = 0; wr_addr_a = 3; wr_data_a = 32'h303;
    tick(); wr_off(); clr_req = 1; set_rd(1, 3); #3;
    check("r1_loaded", rd_data[0 +: DW], 32'h101);
    check("r3_loaded", rd_data[DW +: DW], 32'h303);
    check("busy_before_clr", DW'(busy), 0);
    tick(); clr_req = 0;
    wr_en_a = 1; wr_addr_a = 2; wr_data_a = 32'hDEAD;
    count_busy(n);
    wr_off();
    check("busy_after_clr", DW'(n), 32);
    tick(); set_rd(1, 2); #3;
    check("r1_cleared", rd_data[0 +: DW], 32'h0);
    check("r2_cleared", rd_data[DW +: DW], 32'h0);
    tick(); set_rd(3, 3); #3;
    check("r3_cleared", rd_data[0 +: DW], 32'h0);

    // reset ten cycles into a clear restarts the full sequence
    tick(); clr_req = 1;
    tick(); clr_req = 0;
    repeat (9) tick();
    rst = 1;
    tick(); rst = 0;
    count_busy(n);
    check("busy_after_mid_rst", DW'(n), 32);

    // randomized traffic, small address window to provoke collisions
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst     = ($urandom_range(0, 399) == 0);
      clr_req = ($urandom_range(0, 199) == 0);
      wr_en_a = $urandom_range(0, 1);
      wr_en_b = $urandom_range(0, 1);
      wr_addr_a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      wr_addr_b = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      wr_data_a = $urandom;
      wr_data_b = $urandom;
      set_rd(($urandom_range(0, 2) == 0) ? int'(wr_addr_a) : $urandom_range(0, 7),
             ($urandom_range(0, 2) == 0) ? int'(wr_addr_b) : $urandom_range(0, DEPTH - 1));
    end

    tick(); rst = 0; clr_req = 0; wr_off();
    tick(); #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
